// File: rtl/md_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer: MD opcodes, default
// latencies, FSM states and the 64-bit {HI,LO} result type.
package md_sequencer_pkg;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic [2:0] {
    MDOP_NONE  = 3'd0,
    MDOP_MULT  = 3'd1,
    MDOP_MULTU = 3'd2,
    MDOP_DIV   = 3'd3,
    MDOP_DIVU  = 3'd4,
    MDOP_MTHI  = 3'd5,
    MDOP_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } md_result_t;

  // Only these opcodes occupy the unit for multiple cycles.
  function automatic logic is_arith_op(input logic [2:0] op);
    return (op == MDOP_MULT) || (op == MDOP_MULTU) ||
           (op == MDOP_DIV)  || (op == MDOP_DIVU);
  endfunction

  function automatic logic is_mult_op(input logic [2:0] op);
    return (op == MDOP_MULT) || (op == MDOP_MULTU);
  endfunction

  function automatic int max_int(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/md_sequencer_if.sv
// E-stage issue port of the MD unit: operation request in, busy and HI/LO out.
interface md_sequencer_if;

  logic        i_start;
  logic [2:0]  i_op;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic        o_busy;
  logic [31:0] o_hi;
  logic [31:0] o_lo;

  modport master (
    output i_start, i_op, i_a, i_b,
    input  o_busy, o_hi, o_lo
  );

  modport slave (
    input  i_start, i_op, i_a, i_b,
    output o_busy, o_hi, o_lo
  );

endinterface

// File: rtl/md_sequencer_arith.sv
// Combinational MIPS multiply/divide datapath: op/a/b -> {hi,lo} plus a
// divide-by-zero flag. The sequencer decides when the result is committed.
module md_arith
  import md_sequencer_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output md_result_t  result,
  output logic        div_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] div_den;
  logic [31:0] div_num;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] sq;
  logic [31:0] sr;

  // Low 64 bits of the product of sign-extended operands equal the signed product.
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  assign mag_a = a[31] ? (32'd0 - a) : a;
  assign mag_b = b[31] ? (32'd0 - b) : b;

  // Signed division runs on magnitudes; 0x80000000 / -1 wraps back to 0x80000000.
  always_comb begin
    div_num = a;
    div_den = b;
    if (op == MDOP_DIV) begin
      div_num = mag_a;
      div_den = mag_b;
    end
    if (div_den == 32'd0) begin
      div_den = 32'd1;
    end
  end

  assign uq = div_num / div_den;
  assign ur = div_num % div_den;
  assign sq = (a[31] ^ b[31]) ? (32'd0 - uq) : uq;
  assign sr = a[31] ? (32'd0 - ur) : ur;

  always_comb begin
    result   = '0;
    div_zero = 1'b0;
    case (op)
      MDOP_MULT: begin
        result.hi = prod_s[63:32];
        result.lo = prod_s[31:0];
      end
      MDOP_MULTU: begin
        result.hi = prod_u[63:32];
        result.lo = prod_u[31:0];
      end
      MDOP_DIV: begin
        div_zero = (b == 32'd0);
        result.hi = sr;
        result.lo = sq;
      end
      MDOP_DIVU: begin
        div_zero = (b == 32'd0);
        result.hi = ur;
        result.lo = uq;
      end
      default: begin
        result = '0;
      end
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// Multiply/divide controller for the E stage: owns HI/LO, sequences the
// multi-cycle countdown and raises busy for the hazard unit's MD stall.
module md_sequencer
  import md_sequencer_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic          clk,
  input  logic          reset,
  md_sequencer_if.slave bus
);

  localparam int MAX_CYCLES = max_int(MULT_CYCLES, DIV_CYCLES);
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  md_state_e   state_q;
  md_state_e   state_n;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_n;
  md_result_t  pend_q;
  md_result_t  pend_n;
  logic        pend_dbz_q;
  logic        pend_dbz_n;
  logic [31:0] hi_q;
  logic [31:0] hi_n;
  logic [31:0] lo_q;
  logic [31:0] lo_n;

  md_result_t  arith_res;
  logic        arith_dbz;
  logic        start_arith;

  md_arith u_arith (
    .op       (bus.i_op),
    .a        (bus.i_a),
    .b        (bus.i_b),
    .result   (arith_res),
    .div_zero (arith_dbz)
  );

  assign start_arith = (state_q == ST_IDLE) && bus.i_start && is_arith_op(bus.i_op);

  // Busy covers the start cycle so a dependent MD op in D stalls immediately.
  assign bus.o_busy = (state_q == ST_BUSY) || start_arith;
  assign bus.o_hi   = hi_q;
  assign bus.o_lo   = lo_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      pend_q     <= '0;
      pend_dbz_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_n;
      count_q    <= count_n;
      pend_q     <= pend_n;
      pend_dbz_q <= pend_dbz_n;
      hi_q       <= hi_n;
      lo_q       <= lo_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    count_n    = count_q;
    pend_n     = pend_q;
    pend_dbz_n = pend_dbz_q;
    hi_n       = hi_q;
    lo_n       = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start_arith) begin
          state_n    = ST_BUSY;
          pend_n     = arith_res;
          pend_dbz_n = arith_dbz;
          count_n    = is_mult_op(bus.i_op) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        end else if (bus.i_start && (bus.i_op == MDOP_MTHI)) begin
          hi_n = bus.i_a;
        end else if (bus.i_start && (bus.i_op == MDOP_MTLO)) begin
          lo_n = bus.i_a;
        end
      end
      ST_BUSY: begin
        // Any start seen here is dropped; the hazard unit should never issue one.
        count_n = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_n = ST_IDLE;
          if (!pend_dbz_q) begin
            hi_n = pend_q.hi;
            lo_n = pend_q.lo;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Directed scoreboard bench for md_sequencer: expected HI/LO and busy length
// are queued at issue and checked when busy falls.
module tb_md_sequencer;
  import md_sequencer_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  exp_t sb[$];
  exp_t e;

  md_sequencer_if bus ();

  md_sequencer #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
    end
  endtask

  // Drives one op for a single cycle; arithmetic ops push their expectation.
  task automatic apply_stimulus(input string tag, input logic [2:0] op,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                                input int cycles);
    exp_t x;
    bus.i_start = 1'b1;
    bus.i_op    = op;
    bus.i_a     = a;
    bus.i_b     = b;
    #1;
    check32({tag, "_busy_start"}, {31'd0, bus.o_busy}, (cycles > 0) ? 32'd1 : 32'd0);
    if (cycles > 0) begin
      x.hi = exp_hi;
      x.lo = exp_lo;
      x.cycles = cycles;
      sb.push_back(x);
    end
    tick();
    bus.i_start = 1'b0;
    bus.i_op    = 3'(MDOP_NONE);
    bus.i_a     = $urandom;
    bus.i_b     = $urandom;
  endtask

  // Called one cycle after the start: counts busy cycles, then checks HI/LO.
  task automatic check_output(input string tag);
    exp_t x;
    int   n;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s scoreboard_empty observed=0 expected=1", tag);
      return;
    end
    x = sb.pop_front();
    n = 1;
    while (bus.o_busy === 1'b1 && n < 200) begin
      n++;
      tick();
    end
    check32({tag, "_busy_cycles"}, 32'(n), 32'(x.cycles));
    check32({tag, "_hi"}, bus.o_hi, x.hi);
    check32({tag, "_lo"}, bus.o_lo, x.lo);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.i_start = 1'b0;
    bus.i_op    = 3'(MDOP_NONE);
    bus.i_a     = '0;
    bus.i_b     = '0;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    check32("reset_busy", {31'd0, bus.o_busy}, 32'd0);
    check32("reset_hi", bus.o_hi, 32'd0);
    check32("reset_lo", bus.o_lo, 32'd0);
    tick();

    apply_stimulus("mult", 3'(MDOP_MULT), 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 6);
    check_output("mult");
    apply_stimulus("multu", 3'(MDOP_MULTU), 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 6);
    check_output("multu");
    apply_stimulus("div", 3'(MDOP_DIV), 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 11);
    check_output("div");
    apply_stimulus("divu", 3'(MDOP_DIVU), 32'd7, 32'd2, 32'd1, 32'd3, 11);
    check_output("divu");

    apply_stimulus("mthi", 3'(MDOP_MTHI), 32'h1234_5678, 32'd0, 32'd0, 32'd0, 0);
    check32("mthi_hi", bus.o_hi, 32'h1234_5678);
    check32("mthi_busy", {31'd0, bus.o_busy}, 32'd0);
    apply_stimulus("mtlo", 3'(MDOP_MTLO), 32'h9ABC_DEF0, 32'd0, 32'd0, 32'd0, 0);
    check32("mtlo_lo", bus.o_lo, 32'h9ABC_DEF0);
    check32("mtlo_hi_kept", bus.o_hi, 32'h1234_5678);

    apply_stimulus("divu_zero", 3'(MDOP_DIVU), 32'd5, 32'd0, 32'h1234_5678, 32'h9ABC_DEF0, 11);
    check_output("divu_zero");
    apply_stimulus("div_ovf", 3'(MDOP_DIV), 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 11);
    check_output("div_ovf");

    // Starts arriving while busy must leave the running MULT untouched.
    apply_stimulus("late", 3'(MDOP_MULT), 32'd3, 32'd4, 32'd0, 32'd12, 6);
    tick();
    bus.i_start = 1'b1;
    bus.i_op    = 3'(MDOP_MTLO);
    bus.i_a     = 32'h0000_DEAD;
    #1;
    check32("late_mtlo_busy", {31'd0, bus.o_busy}, 32'd1);
    tick();
    check32("late_mtlo_lo_kept", bus.o_lo, 32'h8000_0000);
    bus.i_op = 3'(MDOP_MULT);
    bus.i_a  = 32'd7;
    bus.i_b  = 32'd7;
    tick();
    bus.i_start = 1'b0;
    bus.i_op    = 3'(MDOP_NONE);
    tick();
    check32("late_busy_t5", {31'd0, bus.o_busy}, 32'd1);
    tick();
    e = sb.pop_front();
    check32("late_busy_t6", {31'd0, bus.o_busy}, 32'd0);
    check32("late_hi", bus.o_hi, e.hi);
    check32("late_lo", bus.o_lo, e.lo);

    // Reset in the middle of a DIV discards the pending result.
    apply_stimulus("rst_div", 3'(MDOP_DIV), 32'd100, 32'd7, 32'd2, 32'd14, 11);
    tick();
    reset = 1'b1;
    tick();
    void'(sb.pop_front());
    check32("rst_busy", {31'd0, bus.o_busy}, 32'd0);
    check32("rst_hi", bus.o_hi, 32'd0);
    check32("rst_lo", bus.o_lo, 32'd0);
    tick();
    check32("rst_idle_busy", {31'd0, bus.o_busy}, 32'd0);
    check32("rst_idle_lo", bus.o_lo, 32'd0);
    reset = 1'b0;
    apply_stimulus("post_rst", 3'(MDOP_MULT), 32'd2, 32'd3, 32'd0, 32'd6, 6);
    check_output("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
